// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every bus signal around mem_arbiter.
//
// Parameters:
//   XLEN   - data/address width of the main and fetch requester ports
//   RAM_AW - byte-address width of the single-ported RAM
//
// Signal groups:
//   main_*  - load/store requester (req held until done; done/rdata/err back)
//   fetch_* - instruction-fetch requester (always a word load)
//   ram_*   - byte-wide RAM port (read data arrives the cycle after ram_re)
//
// Modports:
//   master - the requesters and the RAM (drives requests and ram_rdata)
//   slave  - the arbiter itself
interface mem_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int RAM_AW = 16
);
    logic              main_req;
    logic              main_we;
    logic [1:0]        main_width;
    logic [XLEN-1:0]   main_addr;
    logic [XLEN-1:0]   main_wdata;
    logic              main_done;
    logic [XLEN-1:0]   main_rdata;
    logic              main_err;

    logic              fetch_req;
    logic [XLEN-1:0]   fetch_addr;
    logic              fetch_done;
    logic [31:0]       fetch_data;
    logic              fetch_err;

    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [7:0]        ram_rdata;

    modport master (
        output main_req, main_we, main_width, main_addr, main_wdata,
        input  main_done, main_rdata, main_err,
        output fetch_req, fetch_addr,
        input  fetch_done, fetch_data, fetch_err,
        input  ram_addr, ram_wdata, ram_we, ram_re,
        output ram_rdata
    );

    modport slave (
        input  main_req, main_we, main_width, main_addr, main_wdata,
        output main_done, main_rdata, main_err,
        input  fetch_req, fetch_addr,
        output fetch_done, fetch_data, fetch_err,
        output ram_addr, ram_wdata, ram_we, ram_re,
        input  ram_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM between a load/store port (main) and
// an instruction-fetch port (fetch). Multi-byte accesses are serialised one
// byte per cycle, little-endian, starting at (addr - MEM_BASE).
//
// Ports:
//   clk   - sole clock, all state on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mem_arbiter_if.slave: main_*, fetch_* requester handshakes and
//           the ram_* byte port
//
// Optional feature (macro MEM_BOUNDS_CHECK_EN):
//   defined   - accesses below MEM_BASE or running past the end of the RAM
//               make no RAM access and complete with err=1, rdata=0
//   undefined - the RAM offset wraps modulo 2^RAM_AW and err is tied 0
module mem_arbiter #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] MEM_BASE = XLEN'(32'hC000_0000),
    parameter int              RAM_AW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } state_t;

    typedef enum logic {
        PORT_MAIN,
        PORT_FETCH
    } port_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        cnt_q;
    port_t             last_grant_q;
    port_t             grant_q;
    port_t             pick;

    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              we_q;
    logic [1:0]        width_q;

    logic [XLEN-1:0]   res_q;
    logic [XLEN-1:0]   res_d;
    logic [XLEN-1:0]   main_rdata_q;
    logic [31:0]       fetch_data_q;

    logic [1:0]        last_idx;
    logic [1:0]        cap_sel;
    logic [XLEN-1:0]   offset;
    logic              fault;
    logic              issuing;
    logic              resp_entry;

    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_re;
    logic              ram_we;

    // Arbitration: a lone request wins outright; on a tie the port that did
    // not win the previous tie gets it (last_grant only moves on contention).
    always_comb begin
        pick = PORT_FETCH;
        if (bus.main_req && bus.fetch_req) begin
            pick = (last_grant_q == PORT_FETCH) ? PORT_MAIN : PORT_FETCH;
        end else if (bus.main_req) begin
            pick = PORT_MAIN;
        end
    end

    // Index of the final byte: 1, 2 or 4 bytes per transfer.
    always_comb begin
        case (width_q)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    assign offset = addr_q - MEM_BASE;

`ifdef MEM_BOUNDS_CHECK_EN
    logic [XLEN:0] span_end;
    logic [XLEN:0] ram_size;

    always_comb begin
        ram_size = (XLEN+1)'(1) << RAM_AW;
        span_end = {1'b0, offset} + (XLEN+1)'(last_idx) + (XLEN+1)'(1);
        fault    = (addr_q < MEM_BASE) || (span_end > ram_size);
    end
`else
    logic unused_offset_hi;

    assign fault            = 1'b0;
    assign unused_offset_hi = ^offset[XLEN-1:RAM_AW];
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.main_req || bus.fetch_req) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (fault) begin
                    state_d = RESP;
                end else if (cnt_q == last_idx) begin
                    state_d = we_q ? RESP : DRAIN;
                end
            end
            DRAIN:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM port: active only while issuing a non-faulting transfer.
    always_comb begin
        issuing   = (state_q == ISSUE) && !fault;
        ram_re    = issuing && !we_q;
        ram_we    = issuing && we_q;
        ram_addr  = '0;
        ram_wdata = '0;
        if (issuing) begin
            ram_addr = offset[RAM_AW-1:0] + RAM_AW'(cnt_q);
        end
        if (ram_we) begin
            ram_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
        end
    end

    // Read data lags ram_re by one cycle: while issuing byte k the RAM is
    // returning byte k-1, and DRAIN picks up the final byte.
    always_comb begin
        res_d   = res_q;
        cap_sel = cnt_q - 2'd1;
        if (state_q == DRAIN) begin
            cap_sel = last_idx;
            res_d[{cap_sel, 3'b000} +: 8] = bus.ram_rdata;
        end else if (ram_re && (cnt_q != 2'd0)) begin
            res_d[{cap_sel, 3'b000} +: 8] = bus.ram_rdata;
        end
    end

    // Result registers load on the edge into RESP so they are valid with done.
    assign resp_entry = (state_q != RESP) && (state_d == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= PORT_FETCH;
            grant_q      <= PORT_MAIN;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            width_q      <= '0;
            res_q        <= '0;
            main_rdata_q <= '0;
            fetch_data_q <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;

            if (state_q == IDLE && (bus.main_req || bus.fetch_req)) begin
                grant_q <= pick;
                if (bus.main_req && bus.fetch_req) begin
                    last_grant_q <= pick;
                end
                cnt_q <= '0;
                res_q <= '0;
                if (pick == PORT_MAIN) begin
                    addr_q  <= bus.main_addr;
                    we_q    <= bus.main_we;
                    width_q <= bus.main_width;
                    wdata_q <= bus.main_wdata;
                end else begin
                    addr_q  <= bus.fetch_addr;
                    we_q    <= 1'b0;
                    width_q <= 2'b10;
                    wdata_q <= '0;
                end
            end

            if (issuing) begin
                cnt_q <= cnt_q + 2'd1;
            end

            if (resp_entry) begin
                if (grant_q == PORT_MAIN) begin
                    main_rdata_q <= res_d;
                end else begin
                    fetch_data_q <= res_d[31:0];
                end
            end
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    logic main_err_q;
    logic fetch_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_err_q  <= 1'b0;
            fetch_err_q <= 1'b0;
        end else if (resp_entry) begin
            if (grant_q == PORT_MAIN) begin
                main_err_q <= fault;
            end else begin
                fetch_err_q <= fault;
            end
        end
    end

    assign bus.main_err  = main_err_q;
    assign bus.fetch_err = fetch_err_q;
`else
    assign bus.main_err  = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif

    assign bus.main_done  = (state_q == RESP) && (grant_q == PORT_MAIN);
    assign bus.fetch_done = (state_q == RESP) && (grant_q == PORT_FETCH);
    assign bus.main_rdata = main_rdata_q;
    assign bus.fetch_data = fetch_data_q;
    assign bus.ram_addr   = ram_addr;
    assign bus.ram_wdata  = ram_wdata;
    assign bus.ram_re     = ram_re;
    assign bus.ram_we     = ram_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A byte-array RAM sits
// on the ram_* port; a separate reference memory plus tie-order flag predict
// data, error, latency, RAM addresses and grant order per transaction.
// Honours MEM_BOUNDS_CHECK_EN the same way as the design.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int          XLEN     = 32;
    localparam int          RAM_AW   = 16;
    localparam int          RAM_SIZE = 1 << RAM_AW;
    localparam logic [31:0] BASE     = 32'hC000_0000;

    typedef struct packed {
        logic        act;
        logic        we;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.XLEN(XLEN), .RAM_AW(RAM_AW)) bus ();

    mem_arbiter #(.XLEN(XLEN), .MEM_BASE(BASE), .RAM_AW(RAM_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Physical RAM attached to the DUT.
    logic [7:0] ram [RAM_SIZE];
    always @(posedge clk) begin
        if (bus.ram_re) bus.ram_rdata <= ram[bus.ram_addr];
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    end

    // Reference model state.
    logic [7:0]  model_mem [RAM_SIZE];
    bit          tie_main_first;
    logic [31:0] last_main_rdata;
    logic [31:0] last_fetch_data;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [RAM_AW-1:0] ram_off(input logic [31:0] off, input int k);
        return RAM_AW'(off + 32'(k));
    endfunction

    function automatic bit is_fault(input logic [31:0] a, input int n);
`ifdef MEM_BOUNDS_CHECK_EN
        longint off;
        off = longint'(a) - longint'(BASE);
        return (a < BASE) || (off + longint'(n) > longint'(RAM_SIZE));
`else
        return (a === 32'hx) && (n < 0);
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] off, input int n);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = model_mem[ram_off(off, k)];
        return r;
    endfunction

    function automatic txn_t mk(input logic we, input logic [1:0] w,
                                input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.act = 1'b1; t.we = we; t.width = w; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rand_txn(input bit fetch);
        txn_t        t;
        int          sel;
        logic [31:0] off;
        sel = $urandom_range(0, 9);
        if (sel < 7)      off = 32'($urandom_range(0, 63));
        else if (sel < 9) off = 32'(RAM_SIZE - 8) + 32'($urandom_range(0, 7));
        else              off = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        t.act   = 1'b1;
        t.addr  = BASE + off;
        t.we    = fetch ? 1'b0 : 1'($urandom_range(0, 1));
        t.width = fetch ? 2'b10 : 2'($urandom_range(0, 3));
        t.wdata = $urandom;
        return t;
    endfunction

    // Drives one or both requesters (tm = main, tf = fetch) and follows them to
    // completion, returning in the idle cycle after the last done.
    task automatic run(input txn_t tm, input txn_t tf);
        txn_t        tx [2];
        int          order [$];
        int          srv, start, acc, lat, n;
        logic [31:0] off, exp_rd;
        bit          flt;
        tx[0] = tm; tx[1] = tf;
        bus.main_req   = tm.act;
        bus.main_we    = tm.we;
        bus.main_width = tm.width;
        bus.main_addr  = tm.addr;
        bus.main_wdata = tm.wdata;
        bus.fetch_req  = tf.act;
        bus.fetch_addr = tf.addr;
        if (tm.act && tf.act) begin
            if (tie_main_first) order = '{0, 1};
            else                order = '{1, 0};
            tie_main_first = !tie_main_first;
        end else if (tm.act) begin
            order = '{0};
        end else if (tf.act) begin
            order = '{1};
        end
        srv = (order.size() != 0) ? order[0] : 0;
        start = 0; acc = 0;
        for (int cyc = 1; cyc <= 40 && order.size() != 0; cyc++) begin
            @(negedge clk);
            n   = nbytes(tx[srv].width);
            off = tx[srv].addr - BASE;
            flt = is_fault(tx[srv].addr, n);
            check("ram_re_we_excl", 64'(bus.ram_re & bus.ram_we), 0);
            if (bus.ram_re || bus.ram_we) begin
                check("ram_addr", 64'(bus.ram_addr), 64'(ram_off(off, acc)));
                check("ram_dir", 64'(bus.ram_we), 64'(tx[srv].we));
                if (tx[srv].we)
                    check("ram_wdata", 64'(bus.ram_wdata), 64'(8'(tx[srv].wdata >> (8*acc))));
                acc++;
            end
            if (bus.main_done || bus.fetch_done) begin
                lat = flt ? 2 : (tx[srv].we ? n + 1 : n + 2);
                check("done_port", 64'({bus.main_done, bus.fetch_done}), (srv == 0) ? 64'd2 : 64'd1);
                check("done_latency", 64'(cyc - start), 64'(lat));
                check("ram_accesses", 64'(acc), flt ? 64'd0 : 64'(n));
                exp_rd = (flt || tx[srv].we) ? 32'h0 : model_load(off, n);
                if (srv == 0) begin
                    check("main_rdata", 64'(bus.main_rdata), 64'(exp_rd));
                    check("main_err", 64'(bus.main_err), 64'(flt));
                    check("fetch_data_hold", 64'(bus.fetch_data), 64'(last_fetch_data));
                    last_main_rdata = exp_rd;
                    bus.main_req = 1'b0;
                end else begin
                    check("fetch_data", 64'(bus.fetch_data), 64'(exp_rd));
                    check("fetch_err", 64'(bus.fetch_err), 64'(flt));
                    check("main_rdata_hold", 64'(bus.main_rdata), 64'(last_main_rdata));
                    last_fetch_data = exp_rd;
                    bus.fetch_req = 1'b0;
                end
                if (tx[srv].we && !flt)
                    for (int k = 0; k < n; k++) model_mem[ram_off(off, k)] = 8'(tx[srv].wdata >> (8*k));
                void'(order.pop_front());
                if (order.size() != 0) begin
                    srv = order[0]; start = cyc + 1; acc = 0;
                end
            end
        end
        check("txn_completed", 64'(order.size()), 0);
        bus.main_req  = 1'b0;
        bus.fetch_req = 1'b0;
        @(negedge clk);
    endtask

    txn_t none;
    logic [31:0] exp_word;

    initial begin
        none = '0;
        for (int i = 0; i < RAM_SIZE; i++) begin
            ram[i] = 8'h00;
            model_mem[i] = 8'h00;
        end
        tie_main_first  = 1'b1;
        last_main_rdata = '0;
        last_fetch_data = '0;
        bus.main_req = 1'b0; bus.main_we = 1'b0; bus.main_width = 2'b00;
        bus.main_addr = '0; bus.main_wdata = '0;
        bus.fetch_req = 1'b0; bus.fetch_addr = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_main_done", 64'(bus.main_done), 0);
        check("rst_fetch_done", 64'(bus.fetch_done), 0);
        check("rst_ram_re", 64'(bus.ram_re), 0);
        check("rst_ram_we", 64'(bus.ram_we), 0);
        check("rst_ram_addr", 64'(bus.ram_addr), 0);
        check("rst_ram_wdata", 64'(bus.ram_wdata), 0);
        check("rst_main_rdata", 64'(bus.main_rdata), 0);
        check("rst_fetch_data", 64'(bus.fetch_data), 0);
        check("rst_main_err", 64'(bus.main_err), 0);
        check("rst_fetch_err", 64'(bus.fetch_err), 0);
        rst_n = 1'b1;

        // Tie after reset: main word store wins, fetch of the same word follows.
        run(mk(1'b1, 2'b10, BASE + 32'h10, 32'hDEAD_BEEF), mk(1'b0, 2'b10, BASE + 32'h10, 32'h0));
        exp_word = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++)
            check("store_byte", 64'(ram[16'h10 + k]), 64'(exp_word[8*k +: 8]));
        // Second tie: fetch now goes first; main halfword load sees 0000BEEF.
        run(mk(1'b0, 2'b01, BASE + 32'h10, 32'h0), mk(1'b0, 2'b10, BASE + 32'h12, 32'h0));
        run(mk(1'b0, 2'b01, BASE + 32'h10, 32'h0), none);
        check("half_load_value", 64'(bus.main_rdata), 64'h0000_BEEF);
        run(mk(1'b0, 2'b00, BASE + 32'h13, 32'h0), none);
        run(mk(1'b0, 2'b11, BASE + 32'h10, 32'h0), none);

        // Top-of-RAM word load: wraps, or faults with the bounds check.
        run(mk(1'b1, 2'b01, BASE + 32'hFFFE, 32'h0000_1234), none);
        run(mk(1'b1, 2'b01, BASE, 32'h0000_5678), none);
        run(mk(1'b0, 2'b10, BASE + 32'hFFFE, 32'h0), none);
        run(none, mk(1'b0, 2'b10, BASE - 32'h4, 32'h0));

        // Reset during the third byte of a word store.
        bus.main_req = 1'b1; bus.main_we = 1'b1; bus.main_width = 2'b10;
        bus.main_addr = BASE + 32'h20; bus.main_wdata = 32'hAABB_CCDD;
        repeat (3) @(negedge clk);
        check("mid_store_addr", 64'(bus.ram_addr), 64'h22);
        rst_n = 1'b0;
        #1;
        check("rst_async_we", 64'(bus.ram_we), 0);
        check("rst_async_addr", 64'(bus.ram_addr), 0);
        check("rst_async_wdata", 64'(bus.ram_wdata), 0);
        check("rst_async_rdata", 64'(bus.main_rdata), 0);
        check("rst_async_fdata", 64'(bus.fetch_data), 0);
        bus.main_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_no_done", 64'(bus.main_done), 0);
        end
        rst_n = 1'b1;
        check("kept_byte0", 64'(ram[16'h20]), 64'hDD);
        check("kept_byte1", 64'(ram[16'h21]), 64'hCC);
        check("unwritten_byte2", 64'(ram[16'h22]), 64'(model_mem[16'h22]));
        check("unwritten_byte3", 64'(ram[16'h23]), 64'(model_mem[16'h23]));
        model_mem[16'h20] = 8'hDD;
        model_mem[16'h21] = 8'hCC;
        tie_main_first  = 1'b1;
        last_main_rdata = '0;
        last_fetch_data = '0;
        run(mk(1'b0, 2'b01, BASE + 32'h20, 32'h0), none);
        check("post_reset_load", 64'(bus.main_rdata), 64'h0000_CCDD);

        // Randomised traffic: singles and ties.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0:       run(rand_txn(1'b0), none);
                1:       run(none, rand_txn(1'b1));
                default: run(rand_txn(1'b0), rand_txn(1'b1));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, data width of both requester ports.
REQ-002 Parameters SHALL include: MEM_BASE, default 32'hC000_0000, byte address mapped to RAM offset 0.
REQ-003 Parameters SHALL include: RAM_AW, default 16, RAM byte-address width.
REQ-004 Ports SHALL be: clk  in  1  sole clock, all state on rising edge.
REQ-005 Ports SHALL include: rst_n  in  1  asynchronous active-low reset.
REQ-006 Ports SHALL include: main_req  in  1  load/store request, held until main_done.
REQ-007 Ports SHALL include: main_we  in  1  1 = store, 0 = load.
REQ-008 Ports SHALL include: main_width  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-009 Ports SHALL include: main_addr  in  XLEN  byte address; main_wdata  in  XLEN  store data, LSBs used.
REQ-010 Ports SHALL include: main_done  out  1  one-cycle completion pulse; main_rdata  out  XLEN  zero-extended load data; main_err  out  1  fault flag, valid with main_done.
REQ-011 Ports SHALL include: fetch_req  in  1  instruction fetch, always word; fetch_addr  in  XLEN.
REQ-012 Ports SHALL include: fetch_done  out  1  completion pulse; fetch_data  out  32  instruction word; fetch_err  out  1.
REQ-013 Ports SHALL include: ram_addr  out  RAM_AW; ram_wdata  out  8; ram_we  out  1; ram_re  out  1; ram_rdata  in  8, valid the cycle after ram_re.

Function
REQ-014 States SHALL be IDLE, ISSUE, DRAIN, RESP; byte counter cnt 2 bits, byte count n = 1/2/4 by width.
REQ-015 IDLE with any req high SHALL latch winner's addr/we/width/wdata, set cnt=0, go ISSUE next edge.
REQ-016 Both req high in IDLE SHALL grant the port not granted last; last_grant resets to FETCH, so main wins the first tie.
REQ-017 ISSUE cycle k SHALL drive ram_addr = (addr - MEM_BASE) + k, ram_re or ram_we = 1, ram_wdata = wdata byte k (little-endian).
REQ-018 After byte n-1 issued: store SHALL go RESP; load SHALL go DRAIN to capture the last byte.
REQ-019 Load byte k SHALL be captured from ram_rdata in cycle after its issue into result bits [8k+7:8k]; upper bytes zero.
REQ-020 Latency from IDLE-accept cycle T: store done in cycle T+n+1; load done in cycle T+n+2 (byte load T+3, word load T+6).
REQ-021 RESP SHALL pulse granted port's done for exactly one cycle with rdata/err, return IDLE; other port's done stays 0.
REQ-022 ram_re and ram_we SHALL be 0 in IDLE, DRAIN, RESP and never both 1.
REQ-023 Requester SHALL drop req in the cycle after done; req high in that IDLE cycle is a new request.
REQ-024 Requests arriving during ISSUE/DRAIN/RESP SHALL wait; no requester is starved beyond one foreign transaction.
REQ-025 rdata/fetch_data/err SHALL hold last values until the next done of that port.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, cnt 0, last_grant FETCH, all done/err/ram_re/ram_we 0, rdata/fetch_data/ram_addr/ram_wdata 0.
REQ-027 Reset mid-transaction SHALL abandon it with no done pulse; bytes already written remain in RAM.

Configuration
REQ-028 Macro MEM_BOUNDS_CHECK_EN defined: offset = addr - MEM_BASE; if addr < MEM_BASE or offset + n > 2^RAM_AW, no RAM access, go RESP directly, err=1, rdata 0 (done at T+2).
REQ-029 Macro undefined: offset truncated to RAM_AW bits, wraps modulo 2^RAM_AW, err outputs tied 0.

Verification
REQ-030 Word store 32'hDEADBEEF to C000_0010 -> ram_we at offsets 10,11,12,13 with EF,BE,AD,DE; main_done at T+5.
REQ-031 Halfword load from C000_0010 after REQ-030 -> main_rdata 32'h0000BEEF, main_done at T+4.
REQ-032 main_req and fetch_req asserted same cycle after reset -> main served first, fetch_done follows; repeat both -> fetch served first.
REQ-033 With MEM_BOUNDS_CHECK_EN, word load at C000_FFFE -> main_err=1, no ram_re, done at T+2; without macro -> offsets FFFE,FFFF,0000,0001 read.
REQ-034 rst_n low during third byte of word store -> outputs zero same cycle, no main_done, bytes 0-1 retained, next request serviced normally.
